// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the four common-data-bus broadcast slots among NUM_FU functional
//   unit requesters. Each cycle up to four ready results are granted using a
//   rotating round-robin priority pointer. Granted results are registered onto
//   the CDB outputs one cycle later; ungranted requesters keep their result
//   asserted until they win.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   rst               synchronous active-high reset
//   flush             drops all grants this cycle and clears the CDB next cycle
//   req_valid_flat    per-FU result-ready, FU i at bit NUM_FU-1-i
//   req_index_flat    per-FU ROB index, FU 0 in the top field
//   req_value_flat    per-FU result value, FU 0 in the top field
//   req_ready_flat    combinational grant, FU i at bit NUM_FU-1-i
//   cdb_valid_flat    registered slot valids, slot 0 at bit 3
//   cdb_indices_flat  registered slot ROB indices, slot 0 in the top field
//   cdb_values_flat   registered slot values, slot 0 in the top field
//   grant_count       registered number of valid slots (0..4)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU = 6,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_FU-1:0]     req_valid_flat,
    input  logic [NUM_FU*IDX_W-1:0]  req_index_flat,
    input  logic [NUM_FU*DATA_W-1:0] req_value_flat,
    output logic [NUM_FU-1:0]     req_ready_flat,
    output logic [3:0]            cdb_valid_flat,
    output logic [4*IDX_W-1:0]    cdb_indices_flat,
    output logic [4*DATA_W-1:0]   cdb_values_flat,
    output logic [2:0]            grant_count
);

    localparam int             SLOTS    = 4;
    localparam int             FU_IW    = $clog2(NUM_FU);
    localparam logic [3:0]     NUM_FU_L = 4'(NUM_FU);

    // Per-FU request fields, re-indexed so that element i is FU i.
    logic                  w_valid [0:NUM_FU-1];
    logic [IDX_W-1:0]      w_index [0:NUM_FU-1];
    logic [DATA_W-1:0]     w_value [0:NUM_FU-1];
    logic                  w_ready [0:NUM_FU-1];

    // Arbitration results.
    logic [2:0]            w_slot_fu   [0:SLOTS-1];
    logic                  w_slot_used [0:SLOTS-1];
    logic [2:0]            w_grants;
    logic [2:0]            w_last_fu;
    logic [3:0]            w_scan_fu;
    logic [3:0]            w_last_plus;
    logic [2:0]            w_ptr_next;

    // Next-cycle CDB contents.
    logic [3:0]            w_cdb_valid_next;
    logic [4*IDX_W-1:0]    w_cdb_idx_next;
    logic [4*DATA_W-1:0]   w_cdb_val_next;

    // State.
    logic [2:0]            r_ptr;
    logic [3:0]            r_cdb_valid;
    logic [4*IDX_W-1:0]    r_cdb_idx;
    logic [4*DATA_W-1:0]   r_cdb_val;
    logic [2:0]            r_grant_count;

    // Unpack the MSB-first request buses into per-FU arrays.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_valid[i] = req_valid_flat[NUM_FU-1-i];
            w_index[i] = req_index_flat[(NUM_FU-1-i)*IDX_W +: IDX_W];
            w_value[i] = req_value_flat[(NUM_FU-1-i)*DATA_W +: DATA_W];
        end
    end

    // Round-robin scan starting at r_ptr; the first four valid FUs take
    // slots 0..3 in scan order. Reset and flush suppress every grant, and
    // the grant never looks at the FU's index or value fields.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_ready[i] = 1'b0;
        end
        for (int k = 0; k < SLOTS; k++) begin
            w_slot_fu[k]   = 3'd0;
            w_slot_used[k] = 1'b0;
        end
        w_grants  = 3'd0;
        w_last_fu = r_ptr;
        w_scan_fu = 4'd0;

        if (!rst && !flush) begin
            for (int s = 0; s < NUM_FU; s++) begin
                // ptr < NUM_FU and s < NUM_FU, so one subtraction wraps.
                w_scan_fu = {1'b0, r_ptr} + 4'(s);
                if (w_scan_fu >= NUM_FU_L) begin
                    w_scan_fu = w_scan_fu - NUM_FU_L;
                end else begin
                    w_scan_fu = w_scan_fu;
                end

                if (w_valid[w_scan_fu[FU_IW-1:0]] && (w_grants < 3'd4)) begin
                    w_ready[w_scan_fu[FU_IW-1:0]] = 1'b1;
                    w_slot_fu[w_grants[1:0]]      = w_scan_fu[2:0];
                    w_slot_used[w_grants[1:0]]    = 1'b1;
                    w_last_fu                     = w_scan_fu[2:0];
                    w_grants                      = w_grants + 3'd1;
                end else begin
                    w_grants = w_grants;
                end
            end
        end else begin
            w_grants = 3'd0;
        end
    end

    // Repack the per-FU grants onto the MSB-first ready bus.
    always_comb begin
        req_ready_flat = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            req_ready_flat[NUM_FU-1-i] = w_ready[i];
        end
    end

    // Pointer advances past the last granted FU; NUM_FU need not be a power
    // of two, so the wrap is an explicit compare rather than overflow.
    always_comb begin
        w_last_plus = {1'b0, w_last_fu} + 4'd1;
        if (w_grants == 3'd0) begin
            w_ptr_next = r_ptr;
        end else if (w_last_plus >= NUM_FU_L) begin
            w_ptr_next = 3'd0;
        end else begin
            w_ptr_next = w_last_plus[2:0];
        end
    end

    // Route each granted FU's payload to its slot; unused slots carry zeros.
    always_comb begin
        w_cdb_valid_next = 4'd0;
        w_cdb_idx_next   = '0;
        w_cdb_val_next   = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (w_slot_used[k]) begin
                w_cdb_valid_next[SLOTS-1-k]                 = 1'b1;
                w_cdb_idx_next[(SLOTS-1-k)*IDX_W +: IDX_W]   = w_index[w_slot_fu[k][FU_IW-1:0]];
                w_cdb_val_next[(SLOTS-1-k)*DATA_W +: DATA_W] = w_value[w_slot_fu[k][FU_IW-1:0]];
            end else begin
                w_cdb_valid_next[SLOTS-1-k] = 1'b0;
            end
        end
    end

    // CDB output registers and priority pointer. Flush clears the bus like
    // reset but keeps the pointer so fairness survives the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= 3'd0;
            r_cdb_valid   <= 4'd0;
            r_cdb_idx     <= '0;
            r_cdb_val     <= '0;
            r_grant_count <= 3'd0;
        end else if (flush) begin
            r_ptr         <= r_ptr;
            r_cdb_valid   <= 4'd0;
            r_cdb_idx     <= '0;
            r_cdb_val     <= '0;
            r_grant_count <= 3'd0;
        end else begin
            r_ptr         <= w_ptr_next;
            r_cdb_valid   <= w_cdb_valid_next;
            r_cdb_idx     <= w_cdb_idx_next;
            r_cdb_val     <= w_cdb_val_next;
            r_grant_count <= w_grants;
        end
    end

    assign cdb_valid_flat   = r_cdb_valid;
    assign cdb_indices_flat = r_cdb_idx;
    assign cdb_values_flat  = r_cdb_val;
    assign grant_count      = r_grant_count;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 4 common-data-bus (CDB) broadcast slots among NUM_FU functional-unit requesters.
- Each cycle it grants up to 4 completed results using a rotating round-robin priority.
- Granted results are registered onto the CDB outputs, which feed the reorder buffer's cdb_valid/indices/new_values inputs and the reservation-station wakeup logic.
- Ungranted requesters hold their result until they are granted.

Parameters:
- NUM_FU, 6, number of requesting functional units (legal range 4..8).
- IDX_W, 4, ROB index width.
- DATA_W, 16, result value width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; drops all grants and clears the CDB for the next cycle.
- req_valid_flat  in  NUM_FU  per-FU result-ready. FU i is at bit NUM_FU-1-i (FU 0 is the MSB).
- req_index_flat  in  NUM_FU*IDX_W  per-FU ROB index, MSB-first packing (FU 0 in the top field).
- req_value_flat  in  NUM_FU*DATA_W  per-FU result value, MSB-first packing.
- req_ready_flat  out  NUM_FU  combinational grant; FU i is at bit NUM_FU-1-i.
- cdb_valid_flat  out  4  registered slot valids; slot 0 at bit 3.
- cdb_indices_flat  out  4*IDX_W  registered slot ROB indices; slot 0 in the top field.
- cdb_values_flat  out  4*DATA_W  registered slot values; slot 0 in the top field.
- grant_count  out  3  registered number of valid slots (0..4).

Behaviour:
- Reset (rst=1 at posedge):
  - cdb_valid_flat=0, cdb_indices_flat=0, cdb_values_flat=0, grant_count=0.
  - Priority pointer ptr=0.
  - req_ready_flat is 0 during every cycle in which rst is high.
  - Reset mid-operation discards any in-flight grant; the FU keeps its valid asserted and is re-arbitrated after reset.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] in the same cycle.
  - The FU must hold index and value stable while valid && !ready.
  - Ready never depends on the FU's own data fields, only on the valids, ptr, rst and flush.
- Arbitration (combinational, each cycle):
  - Scan FUs in order ptr, ptr+1, ..., ptr+NUM_FU-1, all modulo NUM_FU.
  - The first 4 with valid set are granted.
  - The k-th granted FU in scan order (k=0..3) is assigned slot k.
  - flush=1 forces all ready bits to 0.
- Latency: a result granted in cycle t appears on the CDB slot in cycle t+1 and stays for exactly one cycle.
- Output registers each posedge:
  - Slot k gets valid=1 plus the index/value of its granted FU.
  - Unused slots get valid=0; their index and value fields are driven to 0.
  - grant_count = number of grants.
  - On flush, all outputs are cleared as on reset, but ptr is held.
- Pointer update:
  - If at least one grant: ptr <= (last granted FU index + 1) mod NUM_FU.
  - If no grant: ptr is held.
  - ptr is a 3-bit register; the wrap must use explicit modulo NUM_FU, not natural overflow (NUM_FU may be non-power-of-2).
- Fairness: with every FU continuously valid, each FU is granted at least once every ceil(NUM_FU/4) cycles.
- Boundary cases:
  - Exactly 4 valid: all granted, ptr unchanged modulo NUM_FU if the last granted is ptr-1.
  - 0 valid: all slot valids 0 next cycle.
  - Duplicate ROB indices from two FUs are an FU protocol error; both are broadcast unchanged.

Test Plan:
- Reset: hold rst 2 cycles with all 6 FUs valid -> req_ready_flat=000000 and cdb_valid_flat=0000 during reset; first cycle after reset grants FU0..3 (req_ready_flat=111100); next cycle cdb_valid_flat=1111 with indices of FU0..3 in slots 0..3, grant_count=4; ptr=4.
- Rotation: all 6 FUs valid continuously -> grants per cycle are {0,1,2,3}, {4,5,0,1}, {2,3,4,5}, {0,1,2,3}; every FU served within 2 cycles.
- Sparse: only FU5 valid, index=4'hA, value=16'h0041 -> slot 0 next cycle holds valid=1, idx A, value 0041; cdb_valid_flat=1000; grant_count=1; ptr wraps to 0.
- Backpressure hold: 6 valid, FU4 and FU5 not granted -> they keep valid with stable data and are granted next cycle in slots 0 and 1; their values appear unchanged on the CDB.
- Flush: assert flush in the cycle with 3 valid requests -> ready=0 that cycle; cdb_valid_flat=0000 and grant_count=0 next cycle; ptr unchanged; the requests are granted the cycle after flush drops.
- Idle: no valids for 3 cycles after ptr=2 -> CDB stays all-zero; ptr stays 2; a subsequent FU1+FU3 request grants FU3 in slot 0 and FU1 in slot 1.
